// File: rtl/rv32i_pkg.sv
// Shared definitions for the multicycle RV32I controller: FSM state enum and base opcodes.
// TRAP exists only when ILLEGAL_TRAP_EN is defined.
package rv32i_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
`ifdef ILLEGAL_TRAP_EN
    ,
    TRAP      = 3'd5
`endif
  } state_e;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  // Opcodes that need an EXECUTE cycle (FENCE/SYSTEM retire in DECODE).
  function automatic logic is_exec_op(input logic [6:0] op);
    case (op)
      LOAD, STORE, OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM with inline retired-instruction counter.
// Optional ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP until reset.
module multicycle_control
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [6:0]      opcode,
  input  logic            branch_taken,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_write_en,
  output logic            addr_sel,
  output logic            ir_write_en,
  output logic            pc_write_en,
  output logic            pc_src,
  output logic            rf_write_en,
  output logic [2:0]      state,
  output logic [XLEN-1:0] instret,
  output logic            trap
);

  state_e          state_q, state_d;
  logic            run_q;
  logic [XLEN-1:0] instret_q;

  // run_q keeps mem_req low for the first cycle after a reset edge, aborting any access.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      run_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_d == FETCH && state_q != FETCH) begin
        instret_q <= instret_q + XLEN'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_write_en = 1'b0;
    addr_sel     = 1'b0;
    ir_write_en  = 1'b0;
    pc_write_en  = 1'b0;
    pc_src       = 1'b0;
    rf_write_en  = 1'b0;
    case (state_q)
      FETCH: begin
        if (run_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write_en = 1'b1;
            pc_write_en = 1'b1;
            state_d     = DECODE;
          end
        end
      end
      DECODE: begin
        if (is_exec_op(opcode)) begin
          state_d = EXECUTE;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = (opcode == FENCE || opcode == SYSTEM) ? FETCH : TRAP;
`else
          state_d = FETCH;
`endif
        end
      end
      EXECUTE: begin
        case (opcode)
          LOAD, STORE:            state_d = MEMORY;
          OP, OP_IMM, LUI, AUIPC: state_d = WRITEBACK;
          JAL, JALR: begin
            pc_write_en = 1'b1;
            pc_src      = 1'b1;
            state_d     = WRITEBACK;
          end
          BRANCH: begin
            pc_write_en = branch_taken;
            pc_src      = branch_taken;
            state_d     = FETCH;
          end
          default:                state_d = FETCH;
        endcase
      end
      MEMORY: begin
        mem_req      = 1'b1;
        addr_sel     = 1'b1;
        mem_write_en = (opcode == STORE);
        if (mem_ready) begin
          state_d = (opcode == STORE) ? FETCH : WRITEBACK;
        end
      end
      WRITEBACK: begin
        rf_write_en = 1'b1;
        state_d     = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase
  end

  assign state   = state_q;
  assign instret = instret_q;
`ifdef ILLEGAL_TRAP_EN
  assign trap = (state_q == TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction expected cycle traces built
// from the instruction-class timing rules, compared cycle by cycle against the DUT.
module tb_multicycle_control;
  import rv32i_pkg::*;

  localparam int unsigned XLEN = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [6:0]      opcode;
  logic            branch_taken;
  logic            mem_ready;
  logic            mem_req, mem_write_en, addr_sel, ir_write_en;
  logic            pc_write_en, pc_src, rf_write_en;
  logic [2:0]      state;
  logic [XLEN-1:0] instret;
  logic            trap;

  always #5 clk = ~clk;

  multicycle_control #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write_en(mem_write_en),
    .addr_sel(addr_sel), .ir_write_en(ir_write_en), .pc_write_en(pc_write_en),
    .pc_src(pc_src), .rf_write_en(rf_write_en), .state(state), .instret(instret),
    .trap(trap)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // strobes = {mem_req, addr_sel, mem_write_en, ir_write_en, pc_write_en, pc_src, rf_write_en}
  typedef struct packed {
    logic [2:0] st;
    logic [6:0] strobes;
    logic       mrdy;
    logic       bt;
  } cyc_t;

  cyc_t        trace[$];
  logic [6:0]  cur_op;
  logic        pend_retire;
  int unsigned retired = 0;

  function automatic logic [6:0] strobes_now();
    return {mem_req, addr_sel, mem_write_en, ir_write_en, pc_write_en, pc_src, rf_write_en};
  endfunction

  function automatic logic [31:0] exp_instret();
    return retired % (32'd1 << XLEN);
  endfunction

  function automatic logic listed(input logic [6:0] op);
    return op inside {LOAD, STORE, OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, FENCE, SYSTEM};
  endfunction

  function automatic void add(input state_e st, input logic [6:0] s, input logic mrdy, input logic bt);
    cyc_t c;
    c.st = st; c.strobes = s; c.mrdy = mrdy; c.bt = bt;
    trace.push_back(c);
  endfunction

  // Expected cycles for one instruction: fetch waits, then the class-specific sequence.
  function automatic void build(input logic [6:0] op, input int unsigned fw,
                                input int unsigned mw, input logic bt);
    cur_op = op;
    pend_retire = 1'b1;
    trace.delete();
    for (int unsigned i = 0; i < fw; i++) add(FETCH, 7'b1000000, 1'b0, 1'($urandom));
    add(FETCH, 7'b1001100, 1'b1, 1'($urandom));
    add(DECODE, 7'b0, 1'($urandom), 1'($urandom));
    if (!listed(op)) begin
`ifdef ILLEGAL_TRAP_EN
      pend_retire = 1'b0;
`endif
      return;
    end
    if (op == FENCE || op == SYSTEM) return;
    if (op == BRANCH) begin
      add(EXECUTE, {4'b0, bt, bt, 1'b0}, 1'($urandom), bt);
      return;
    end
    if (op == JAL || op == JALR) add(EXECUTE, 7'b0000110, 1'($urandom), 1'($urandom));
    else                         add(EXECUTE, 7'b0, 1'($urandom), 1'($urandom));
    if (op == LOAD || op == STORE) begin
      for (int unsigned i = 0; i < mw; i++)
        add(MEMORY, {2'b11, op == STORE, 4'b0}, 1'b0, 1'($urandom));
      add(MEMORY, {2'b11, op == STORE, 4'b0}, 1'b1, 1'($urandom));
      if (op == STORE) return;
    end
    add(WRITEBACK, 7'b0000001, 1'($urandom), 1'($urandom));
  endfunction

  task automatic play(input int unsigned limit);
    cyc_t c;
    for (int unsigned i = 0; i < limit && trace.size() > 0; i++) begin
      c = trace.pop_front();
      @(negedge clk);
      opcode = cur_op; mem_ready = c.mrdy; branch_taken = c.bt;
      #1;
      check("state", 32'(state), 32'(c.st));
      check("strobes", 32'(strobes_now()), 32'(c.strobes));
      check("instret", 32'(instret), exp_instret());
      check("trap", 32'(trap), 32'd0);
    end
    if (trace.size() == 0 && pend_retire) retired++;
    trace.delete();
  endtask

  task automatic run_instr(input logic [6:0] op, input int unsigned fw,
                           input int unsigned mw, input logic bt);
    build(op, fw, mw, bt);
    play(1000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    mem_ready = 1'($urandom);
    @(negedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_state", 32'(state), 32'(FETCH));
    check("rst_instret", 32'(instret), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    retired = 0;
    reset_n = 1'b1;
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] ops [11] = '{LOAD, STORE, OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, FENCE, SYSTEM};
    logic [6:0] op;
`ifndef ILLEGAL_TRAP_EN
    if ($urandom_range(0, 9) == 0) begin
      do op = 7'($urandom); while (listed(op));
      return op;
    end
`endif
    op = ops[$urandom_range(0, 10)];
    return op;
  endfunction

  initial begin
    reset_n = 1'b0; opcode = OP_IMM; mem_ready = 1'b0; branch_taken = 1'b0;
    do_reset();

    run_instr(OP_IMM, 0, 0, 1'b0);
    run_instr(LOAD, 0, 3, 1'b0);
    run_instr(BRANCH, 0, 0, 1'b1);
    run_instr(BRANCH, 0, 0, 1'b0);
    run_instr(STORE, 1, 1, 1'b0);
    run_instr(JAL, 0, 0, 1'b0);
    run_instr(FENCE, 2, 0, 1'b0);

    build(OP_IMM, 3, 0, 1'b0);
    play(2);
    do_reset();
    build(LOAD, 0, 3, 1'b0);
    play(4);
    do_reset();

    for (int n = 0; n < 150; n++) begin
      run_instr(rand_op(), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end

`ifdef ILLEGAL_TRAP_EN
    build(7'b0000000, 0, 0, 1'b0);
    play(1000);
    repeat (4) begin
      @(negedge clk);
      mem_ready = 1'($urandom); branch_taken = 1'($urandom);
      #1;
      check("trap_state", 32'(state), 32'(TRAP));
      check("trap_flag", 32'(trap), 32'd1);
      check("trap_strobes", 32'(strobes_now()), 32'd0);
      check("trap_instret", 32'(instret), exp_instret());
    end
    do_reset();
    run_instr(OP_IMM, 0, 0, 1'b0);
`else
    run_instr(7'b0000000, 0, 0, 1'b0);
    run_instr(OP_IMM, 0, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
